ntt_unload: RTL and testbench

NTT_UNLOAD -- requirements
Module: ntt_unload

---
 rtl/ntt_unload.sv | 140 ++++++++++++++
 tb/tb_ntt_unload.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_unload.sv
// ntt_unload: streams N_COEF 24-bit coefficients from a synchronous-read
// coefficient memory onto a valid/ready output through a 2-entry FIFO.
module ntt_unload #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int unsigned N_COEF    = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_unload,
  output logic        busy,
  output logic        done_unload,
  output logic [15:0] mem_A,
  output logic        mem_CEB,
  output logic        mem_WEB,
  input  logic [23:0] mem_Q,
  output logic [23:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last
);

  localparam int unsigned CW = $clog2(N_COEF + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  issue_cnt;
  logic [CW-1:0]  out_cnt;
  logic [15:0]    addr_q;
  logic           inflight;
  logic [23:0]    fifo_mem [2];
  logic           wr_ptr;
  logic           rd_ptr;
  logic [1:0]     fifo_count;

  logic           issue;
  logic           pop;
  logic           push;
  logic [15:0]    issue_addr;

  // Read credit counts the pop happening this cycle, so a slot freed now can
  // be refilled by the read issued now; this is what allows one handshake
  // per cycle with only two entries of storage.
  always_comb begin
    pop        = (fifo_count != 2'd0) && out_ready;
    push       = inflight;
    issue_addr = BASE_ADDR + 16'(issue_cnt);
    issue      = (state == READ) && (issue_cnt < CW'(N_COEF)) &&
                 (({1'b0, fifo_count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
  end

  assign mem_CEB   = ~issue;
  assign mem_WEB   = 1'b1;
  assign mem_A     = issue ? issue_addr : addr_q;
  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = fifo_mem[rd_ptr];
  assign out_last  = out_valid && (out_cnt == CW'(N_COEF - 1));

  // Control FSM with registered busy / done_unload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done_unload <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_unload <= 1'b0;
          if (start_unload) begin
            state <= READ;
            busy  <= 1'b1;
          end
        end
        READ: begin
          if (issue && (issue_cnt == CW'(N_COEF - 1))) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && (out_cnt == CW'(N_COEF - 1))) begin
            state       <= DONE;
            busy        <= 1'b0;
            done_unload <= 1'b1;
          end
        end
        DONE: begin
          state       <= IDLE;
          done_unload <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          done_unload <= 1'b0;
        end
      endcase
    end
  end

  // Issue/output counters, last address and the in-flight read flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      out_cnt   <= '0;
      addr_q    <= BASE_ADDR;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      if (state == IDLE && start_unload) begin
        issue_cnt <= '0;
        out_cnt   <= '0;
      end else begin
        if (issue) begin
          issue_cnt <= issue_cnt + 1'b1;
          addr_q    <= issue_addr;
        end
        if (pop) out_cnt <= out_cnt + 1'b1;
      end
    end
  end

  // Two-entry output FIFO; the memory result lands one cycle after its issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) fifo_mem[i] <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= mem_Q;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_unload.sv
// Scoreboard bench for ntt_unload: expected coefficients are queued when a
// start is driven and compared at each output handshake.
module tb_ntt_unload;

  localparam int N = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_unload = 1'b0;
  logic        out_ready = 1'b1;
  logic        busy, done_unload, mem_CEB, mem_WEB, out_valid, out_last;
  logic [15:0] mem_A;
  logic [23:0] mem_Q = '0;
  logic [23:0] out_data;

  logic        start2 = 1'b0;
  logic        busy2, done2, ceb2, web2, valid2, last2;
  logic [15:0] addr2;
  logic [23:0] q2_data = '0;
  logic [23:0] data2;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;
  int hs_cnt, reads_cnt, first_valid_cyc, done_cyc;
  bit valid_seen, done_seen, rand_mode = 0;
  bit prev_stall = 0;
  logic [23:0] held_data;
  logic        held_last;
  logic [24:0] q[$];

  logic [24:0] q2[$];
  int k2 = 0;
  int hs2 = 0;
  bit done2_seen = 0;

  ntt_unload #(.BASE_ADDR(16'h0000), .N_COEF(N)) dut (
    .clk(clk), .rst_n(rst_n), .start_unload(start_unload), .busy(busy),
    .done_unload(done_unload), .mem_A(mem_A), .mem_CEB(mem_CEB), .mem_WEB(mem_WEB),
    .mem_Q(mem_Q), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last));

  ntt_unload #(.BASE_ADDR(16'hFF80), .N_COEF(N)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_unload(start2), .busy(busy2),
    .done_unload(done2), .mem_A(addr2), .mem_CEB(ceb2), .mem_WEB(web2),
    .mem_Q(q2_data), .out_data(data2), .out_valid(valid2), .out_ready(1'b1),
    .out_last(last2));

  always #5 clk = ~clk;

  function automatic logic [23:0] data_at(input logic [15:0] a);
    return 24'(a) * 24'd3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Memory models: read data valid the cycle after the issue cycle.
  initial forever begin
    @(posedge clk);
    if (!mem_CEB) mem_Q <= data_at(mem_A);
    if (!ceb2) q2_data <= data_at(addr2);
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Random backpressure driver, offset from the main driver's #1 writes.
  initial forever begin
    @(posedge clk);
    #2;
    if (rand_mode) out_ready = 1'($urandom_range(0, 1));
  end

  // Output monitor for the BASE_ADDR=0 instance.
  initial forever begin
    logic [24:0] e;
    @(negedge clk);
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (!mem_CEB) reads_cnt++;
      if (out_valid && !valid_seen) begin valid_seen = 1; first_valid_cyc = cyc; end
      if (done_unload) begin done_seen = 1; done_cyc = cyc; end
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(held_data));
        check("stall_last", 32'(out_last), 32'(held_last));
      end
      if (rand_mode) check("fifo_le2", 32'(dut.fifo_count <= 2'd2), 32'd1);
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("unexpected_out", 32'(out_data), 32'hFFFFFFFF);
        else begin
          e = q.pop_front();
          check("data", 32'(out_data), 32'(e[23:0]));
          check("last", 32'(out_last), 32'(e[24]));
        end
        hs_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      held_data  = out_data;
      held_last  = out_last;
    end
  end

  // Monitor for the BASE_ADDR=16'hFF80 instance: addresses and data.
  initial forever begin
    logic [24:0] e;
    @(negedge clk);
    if (rst_n) begin
      if (!ceb2) begin
        check("addr_wrap", 32'(addr2), 32'(16'(16'hFF80 + k2)));
        k2++;
      end
      if (valid2) begin
        if (q2.size() == 0) check("unexpected_out2", 32'(data2), 32'hFFFFFFFF);
        else begin
          e = q2.pop_front();
          check("data2", 32'(data2), 32'(e[23:0]));
          check("last2", 32'(last2), 32'(e[24]));
        end
        hs2++;
      end
      if (done2) done2_seen = 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push_expected(input logic [15:0] base);
    for (int k = 0; k < N; k++)
      q.push_back({(k == N - 1) ? 1'b1 : 1'b0, data_at(16'(base + 16'(k)))});
  endtask

  task automatic clear_mon();
    hs_cnt = 0; reads_cnt = 0; valid_seen = 0; done_seen = 0;
    first_valid_cyc = -1; done_cyc = -1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start_unload = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start_unload = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_seen) break;
      @(posedge clk);
    end
    check("done_seen", 32'(done_seen), 32'd1);
  endtask

  task automatic wait_hs(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (hs_cnt >= n) break;
      @(posedge clk);
    end
    check("hs_reached", 32'(hs_cnt >= n), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done_unload), 32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_last"}, 32'(out_last), 32'd0);
    check({tag, "_data"}, 32'(out_data), 32'd0);
    check({tag, "_ceb"}, 32'(mem_CEB), 32'd1);
    check({tag, "_web"}, 32'(mem_WEB), 32'd1);
    check({tag, "_addr"}, 32'(mem_A), 32'd0);
  endtask

  initial begin
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    check("rst_addr2", 32'(addr2), 32'h0000FF80);
    rst_n = 1'b1;

    // Full-rate unload: latency and total length.
    out_ready = 1'b1;
    clear_mon();
    push_expected(16'h0000);
    pulse_start();
    wait_done(400);
    check("first_valid_lat", 32'(first_valid_cyc - start_cyc), 32'd3);
    check("done_lat", 32'(done_cyc - start_cyc), 32'd259);
    check("hs_count", 32'(hs_cnt), 32'(N));
    check("q_empty", 32'(q.size()), 32'd0);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done_unload), 32'd0);
    check("busy_after", 32'(busy), 32'd0);

    // Random backpressure.
    clear_mon();
    push_expected(16'h0000);
    rand_mode = 1;
    pulse_start();
    wait_done(4000);
    rand_mode = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    check("rand_hs_count", 32'(hs_cnt), 32'(N));
    check("rand_q_empty", 32'(q.size()), 32'd0);

    // Held-off consumer: only two reads may be outstanding.
    @(posedge clk); #1;
    out_ready = 1'b0;
    clear_mon();
    push_expected(16'h0000);
    pulse_start();
    repeat (19) @(posedge clk);
    #1;
    check("stall_reads", 32'(reads_cnt), 32'd2);
    check("stall_ceb", 32'(mem_CEB), 32'd1);
    out_ready = 1'b1;
    wait_done(400);
    check("stall_q_empty", 32'(q.size()), 32'd0);

    // Start while busy is ignored.
    clear_mon();
    push_expected(16'h0000);
    pulse_start();
    wait_hs(100, 400);
    @(posedge clk); #1;
    start_unload = 1'b1;
    @(posedge clk); #1;
    start_unload = 1'b0;
    check("busy_mid", 32'(busy), 32'd1);
    wait_done(400);
    check("restart_done_lat", 32'(done_cyc - start_cyc), 32'd259);
    check("restart_hs", 32'(hs_cnt), 32'(N));
    check("restart_q_empty", 32'(q.size()), 32'd0);

    // Reset in the middle of an unload, then a fresh unload.
    @(posedge clk); #1;
    clear_mon();
    push_expected(16'h0000);
    pulse_start();
    wait_hs(50, 400);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_mon();
    push_expected(16'h0000);
    pulse_start();
    wait_done(400);
    check("post_rst_hs", 32'(hs_cnt), 32'(N));
    check("post_rst_q_empty", 32'(q.size()), 32'd0);

    // Address wrap on the second instance.
    for (int k = 0; k < N; k++)
      q2.push_back({(k == N - 1) ? 1'b1 : 1'b0, data_at(16'(16'hFF80 + 16'(k)))});
    k2 = 0; hs2 = 0; done2_seen = 0;
    @(posedge clk); #1;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done2_seen) break;
      @(posedge clk);
    end
    check("wrap_done", 32'(done2_seen), 32'd1);
    check("wrap_reads", 32'(k2), 32'(N));
    check("wrap_hs", 32'(hs2), 32'(N));
    check("wrap_q_empty", 32'(q2.size()), 32'd0);
    @(posedge clk); #1;
    check("wrap_busy", 32'(busy2), 32'd0);
    check("wrap_web", 32'(web2), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
